score_display_fsm: RTL and testbench

Parametrised score-display state for the reaction timer. When enabled by the top-level controller, it captures an N-digit BCD reaction score and drives it onto active-low seven-segment outputs. It holds the display for a configurable time, or until the player presses KEY[0], then reports the next state code. It sits beside the other per-state blocks under the top-level state register. It also adds leading-zero blanking, a best-score register and a "new best" blink.

---
 rtl/score_display_fsm_if.sv | 16 +
 rtl/score_display_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_score_display_fsm.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/score_display_fsm_if.sv
// Bus between the top-level reaction-timer controller and the score-display state block.
// The controller side drives en, KEY and score; the display side returns segments and best score.
interface score_display_fsm_if #(
    parameter int unsigned NUM_DIGITS = 3
);
    logic                    en;
    logic [1:0]              KEY;
    logic [4*NUM_DIGITS-1:0] score;
    logic [8*NUM_DIGITS-1:0] hex;
    logic [4*NUM_DIGITS-1:0] best;
    logic                    best_valid;
    logic [3:0]              out_state;

    modport master (output en, KEY, score, input hex, best, best_valid, out_state);
    modport slave  (input en, KEY, score, output hex, best, best_valid, out_state);
endinterface

// File: rtl/score_display_fsm.sv
// Score-display state of the reaction timer: shows a captured BCD score, then hands over.
// Optional best-score register, "new best" blink and KEY[1] clear are built with BEST_SCORE_EN.
module score_display_fsm #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned HOLD_MS    = 3000,
    parameter int unsigned BLINK_MS   = 250,
    parameter logic [3:0]  STATE_SELF = 4'd3,
    parameter logic [3:0]  STATE_NEXT = 4'd4
) (
    input logic                clk,
    input logic                rst_n,
    score_display_fsm_if.slave bus
);
    localparam int unsigned SW      = 4 * NUM_DIGITS;
    localparam int unsigned HW      = 8 * NUM_DIGITS;
    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MS_W    = $clog2(HOLD_MS + 1);
    localparam int unsigned BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    typedef enum logic [1:0] {StIdle, StShow, StDone} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     cap_q, cap_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic [HW-1:0]     hex_q, hex_d;
    logic [1:0]        key_s1_q, key_s2_q, key_s3_q, press_q;
    logic              tick_wrap, capture, blank_phase, lead;

    assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));
    assign capture   = (state_q == StIdle) && bus.en;

    // Two sync flops, one history flop, then a registered one-cycle press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
            key_s3_q <= 2'b11;
            press_q  <= 2'b00;
        end else begin
            key_s1_q <= bus.KEY;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
            press_q  <= key_s3_q & ~key_s2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        tick_d  = tick_q;
        ms_d    = ms_q;
        if (!bus.en) begin
            state_d = StIdle;
            tick_d  = '0;
            ms_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cap_d   = bus.score;
                    tick_d  = '0;
                    ms_d    = '0;
                    state_d = StShow;
                end
                StShow: begin
                    tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
                    if (tick_wrap) begin
                        ms_d = ms_q + MS_W'(1);
                    end
                    // Exit on the very edge that brings ms up to HOLD_MS, or on a skip press
                    if (press_q[0] || (tick_wrap && ms_q == MS_W'(HOLD_MS - 1))) begin
                        state_d = StDone;
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef BEST_SCORE_EN
    logic [SW-1:0]      best_q, best_d;
    logic               best_valid_q, best_valid_d, new_best_q, new_best_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;

    function automatic logic score_ok(input logic [SW-1:0] v);
        logic ok;
        ok = (v != '0);
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    always_comb begin
        best_d       = best_q;
        best_valid_d = best_valid_q;
        new_best_d   = new_best_q;
        if (state_q == StIdle && press_q[1]) begin
            best_valid_d = 1'b0;
        end
        if (capture) begin
            new_best_d = 1'b0;
            if (score_ok(bus.score) && (!best_valid_d || bus.score < best_q)) begin
                best_d       = bus.score;
                best_valid_d = 1'b1;
                new_best_d   = 1'b1;
            end
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (!bus.en || state_q != StShow) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (tick_wrap) begin
            if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q       <= '0;
            best_valid_q <= 1'b0;
            new_best_q   <= 1'b0;
            blink_cnt_q  <= '0;
            blink_off_q  <= 1'b0;
        end else begin
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            new_best_q   <= new_best_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_off_q  <= blink_off_d;
        end
    end

    assign bus.best       = best_q;
    assign bus.best_valid = best_valid_q;
    assign blank_phase    = new_best_q & blink_off_q;
`else
    logic unused_clear_press;
    assign unused_clear_press = press_q[1];
    assign bus.best           = '0;
    assign bus.best_valid     = 1'b0;
    assign blank_phase        = 1'b0;
`endif

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    // Display follows the current state; dropping en blanks on the very next edge
    always_comb begin
        hex_d = '1;
        lead  = 1'b1;
        if (bus.en && (state_q == StDone || (state_q == StShow && !blank_phase))) begin
            for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
                if (lead && i != 0 && cap_q[4*i +: 4] == 4'd0) begin
                    hex_d[8*i +: 8] = 8'hFF;
                end else begin
                    lead            = 1'b0;
                    hex_d[8*i +: 8] = seg7(cap_q[4*i +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cap_q   <= '0;
            tick_q  <= '0;
            ms_q    <= '0;
            hex_q   <= '1;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            hex_q   <= hex_d;
        end
    end

    assign bus.hex       = hex_q;
    assign bus.out_state = (state_q == StDone) ? STATE_NEXT : STATE_SELF;
endmodule

// File: tb/tb_score_display_fsm.sv
// Bench for score_display_fsm: a cycle model built from the display rules, checked every cycle,
// plus directed literal expectations for the hold, blink, skip, abort, clear and reset scenarios.
module tb_score_display_fsm;
    localparam int unsigned ND = 3;
    localparam int unsigned TD = 4;
    localparam int unsigned HM = 10;
    localparam int unsigned BM = 2;
    localparam int HOLD_CYC  = HM * TD;
    localparam int BLINK_CYC = BM * TD;
    localparam int ST_IDLE = 0;
    localparam int ST_SHOW = 1;
    localparam int ST_DONE = 2;
`ifdef BEST_SCORE_EN
    localparam bit BEST_ON = 1'b1;
`else
    localparam bit BEST_ON = 1'b0;
`endif
    localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    score_display_fsm_if #(.NUM_DIGITS(ND)) bus ();

    score_display_fsm #(
        .NUM_DIGITS(ND), .TICK_DIV(TD), .HOLD_MS(HM), .BLINK_MS(BM),
        .STATE_SELF(4'd3), .STATE_NEXT(4'd4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          mode;
        int          cnt;
        logic        hold_exit;
        logic [11:0] cap;
        logic [11:0] best;
        logic        bv;
        logic        nb;
        logic [4:0]  h0;
        logic [4:0]  h1;
        logic [23:0] hex;
    } model_t;

    model_t m;

    // Shown digits: everything above the most significant non-zero digit is blank
    function automatic logic [23:0] disp(input logic [11:0] v);
        logic [23:0] r;
        int top;
        r = '1;
        top = 0;
        for (int i = 0; i < int'(ND); i++) if (v[4*i +: 4] != 4'd0) top = i;
        for (int i = 0; i <= top; i++) r[8*i +: 8] = SEG[v[4*i +: 4]];
        return r;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.h0 = '1;
        r.h1 = '1;
        r.hex = '1;
        return r;
    endfunction

    // Pin history index k = value sampled k edges ago; a press acts 3 edges after the pin falls
    function automatic model_t step(input model_t c, input logic en, input logic [1:0] key,
                                    input logic [11:0] score);
        model_t n;
        logic p0, p1, ok;
        n = c;
        n.h0 = {c.h0[3:0], key[0]};
        n.h1 = {c.h1[3:0], key[1]};
        p0 = !n.h0[3] && n.h0[4];
        p1 = !n.h1[3] && n.h1[4];
        if (!en) n.hex = '1;
        else if (c.mode == ST_DONE) n.hex = disp(c.cap);
        else if (c.mode == ST_SHOW)
            n.hex = (c.nb && ((c.cnt / BLINK_CYC) % 2 == 1)) ? 24'hFFFFFF : disp(c.cap);
        else n.hex = '1;
        if (BEST_ON && c.mode == ST_IDLE && p1) n.bv = 1'b0;
        if (!en) begin
            n.mode = ST_IDLE;
            n.hold_exit = 1'b0;
        end else if (c.mode == ST_IDLE) begin
            n.cap = score;
            n.cnt = 0;
            n.mode = ST_SHOW;
            n.hold_exit = 1'b0;
            ok = (score != 12'h000);
            for (int i = 0; i < int'(ND); i++) if (score[4*i +: 4] > 4'd9) ok = 1'b0;
            n.nb = 1'b0;
            if (BEST_ON && ok && (!n.bv || score < c.best)) begin
                n.best = score;
                n.bv = 1'b1;
                n.nb = 1'b1;
            end
        end else begin
            n.cnt = c.cnt + 1;
            if (c.mode == ST_SHOW && (n.cnt == HOLD_CYC || p0)) begin
                n.mode = ST_DONE;
                n.hold_exit = (n.cnt == HOLD_CYC);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else m <= step(m, bus.en, bus.KEY, bus.score);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Hold exit may land one edge late, so the cycle pair around it is left to the literals
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (!(m.mode == ST_DONE && m.hold_exit && m.cnt == HOLD_CYC))
                check("model out_state", 32'(bus.out_state), (m.mode == ST_DONE) ? 32'd4 : 32'd3);
            if (!(m.mode == ST_DONE && m.hold_exit && m.cnt == HOLD_CYC + 1))
                check("model hex", 32'(bus.hex), 32'(m.hex));
            check("model best", 32'(bus.best), 32'(m.best));
            check("model best_valid", 32'(bus.best_valid), 32'(m.bv));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.en = 1'b0;
        bus.KEY = 2'b11;
        bus.score = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset hex", 32'(bus.hex), 32'hFFFFFF);
        check("reset out_state", 32'(bus.out_state), 32'd3);
        check("reset best", 32'(bus.best), 32'h0);
        check("reset best_valid", 32'(bus.best_valid), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Hold to timeout with a first (new best) score of 042
        bus.score = 12'h042;
        bus.en = 1'b1;
        tick(2);
        check("run1 hex", 32'(bus.hex), 32'hFF99A4);
        check("run1 best", 32'(bus.best), BEST_ON ? 32'h042 : 32'h0);
        check("run1 best_valid", 32'(bus.best_valid), BEST_ON ? 32'h1 : 32'h0);
        tick(7);
        check("blink shown E0+8", 32'(bus.hex), 32'hFF99A4);
        tick(1);
        check("blink blank E0+9", 32'(bus.hex), BEST_ON ? 32'hFFFFFF : 32'hFF99A4);
        tick(8);
        check("blink shown E0+17", 32'(bus.hex), 32'hFF99A4);
        tick(21);
        check("hold still self E0+38", 32'(bus.out_state), 32'd3);
        tick(3);
        check("hold next E0+41", 32'(bus.out_state), 32'd4);
        check("done steady E0+41", 32'(bus.hex), 32'hFF99A4);
        tick(8);
        check("done steady E0+49", 32'(bus.hex), 32'hFF99A4);
        bus.en = 1'b0;
        tick(1);
        check("exit hex", 32'(bus.hex), 32'hFFFFFF);
        check("exit out_state", 32'(bus.out_state), 32'd3);
        tick(1);

        // Slower score, skipped with KEY[0]
        bus.score = 12'h150;
        bus.en = 1'b1;
        tick(2);
        check("run2 hex", 32'(bus.hex), 32'hF992C0);
        check("run2 best kept", 32'(bus.best), BEST_ON ? 32'h042 : 32'h0);
        tick(8);
        check("run2 no blink", 32'(bus.hex), 32'hF992C0);
        tick(1);
        bus.KEY = 2'b10;
        tick(1);
        bus.KEY = 2'b11;
        tick(2);
        check("skip not yet E0+13", 32'(bus.out_state), 32'd3);
        tick(1);
        check("skip next E0+14", 32'(bus.out_state), 32'd4);
        bus.en = 1'b0;
        tick(2);

        // Abort mid-SHOW, then a fresh hold from zero
        bus.en = 1'b1;
        tick(12);
        bus.en = 1'b0;
        tick(1);
        check("abort hex", 32'(bus.hex), 32'hFFFFFF);
        check("abort out_state", 32'(bus.out_state), 32'd3);
        bus.en = 1'b1;
        tick(39);
        check("restart self E0+38", 32'(bus.out_state), 32'd3);
        tick(3);
        check("restart next E0+41", 32'(bus.out_state), 32'd4);
        bus.en = 1'b0;
        tick(2);

        // Invalid nibble, then clear best with KEY[1] in IDLE
        bus.score = 12'h0A0;
        bus.en = 1'b1;
        tick(2);
        check("invalid hex", 32'(bus.hex), 32'hFFBFC0);
        check("invalid best kept", 32'(bus.best), BEST_ON ? 32'h042 : 32'h0);
        bus.en = 1'b0;
        tick(2);
        bus.KEY = 2'b01;
        tick(1);
        bus.KEY = 2'b11;
        tick(5);
        check("clear best_valid", 32'(bus.best_valid), 32'h0);

        // After a clear any valid score becomes best; reset asynchronously mid-DONE
        bus.score = 12'h150;
        bus.en = 1'b1;
        tick(2);
        check("rebest best", 32'(bus.best), BEST_ON ? 32'h150 : 32'h0);
        check("rebest best_valid", 32'(bus.best_valid), BEST_ON ? 32'h1 : 32'h0);
        tick(48);
        check("rebest done", 32'(bus.out_state), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("async hex", 32'(bus.hex), 32'hFFFFFF);
        check("async out_state", 32'(bus.out_state), 32'd3);
        check("async best", 32'(bus.best), 32'h0);
        check("async best_valid", 32'(bus.best_valid), 32'h0);
        bus.en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
